// File: rtl/osp_cmd_pkg.sv
// Shared constants, state encoding and helpers for the OSP command engine.
package osp_cmd_pkg;

  localparam logic [3:0] OpClr = 4'h0;
  localparam logic [3:0] OpPm  = 4'h1;
  localparam logic [3:0] OpSd  = 4'h5;
  localparam logic [3:0] OpRst = 4'h6;

  localparam logic [3:0] PuIdle    = 4'h0;
  localparam logic [3:0] PuWaitS2  = 4'h1;
  localparam logic [3:0] PuWaitS4  = 4'h2;
  localparam logic [3:0] PuWaitSpm = 4'h3;
  localparam logic [3:0] PuPass    = 4'h8;
  localparam logic [3:0] PuTmo     = 4'h9;
  localparam logic [3:0] PuAbort   = 4'hF;

  localparam int unsigned ErrCmd   = 0;
  localparam int unsigned ErrOvf   = 1;
  localparam int unsigned ErrTmo   = 2;
  localparam int unsigned ErrFault = 3;

  typedef enum logic [2:0] {
    StIdle, StDecode, StPmRun, StSdRun, StRstPulse, StAbort
  } state_e;

  function automatic logic pu_busy(input logic [3:0] n);
    return (n == PuWaitS2) || (n == PuWaitS4) || (n == PuWaitSpm);
  endfunction

  function automatic logic [3:0] pu_next(input logic [3:0] n);
    case (n)
      PuWaitS2:  return PuWaitS4;
      PuWaitS4:  return PuWaitSpm;
      PuWaitSpm: return PuPass;
      default:   return n;
    endcase
  endfunction

endpackage

// File: rtl/osp_cmd_engine_if.sv
// MCU command and OSP monitor/control signal bundle for the command engine.
interface osp_cmd_engine_if #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]      mcu_cmd;
  logic             mcu_cmd_write;
  logic [NCH-1:0]   s2_norm_period;
  logic [NCH-1:0]   s4_norm_period;
  logic [NCH-1:0]   spm_done;
  logic             sys_hard_fault;
  logic [NCH-1:0]   osp_pu_req;
  logic [NCH-1:0]   osp_sd_req;
  logic [NCH-1:0]   osp_rst_n;
  logic [4*NCH-1:0] putest_status;
  logic [NCH-1:0]   sdtest_status;
  logic [NCH-1:0]   osprst_status;
  logic             cmd_busy;
  logic [3:0]       cmd_err;
  logic [LW-1:0]    fifo_level;

  modport master (
    output mcu_cmd, mcu_cmd_write, s2_norm_period, s4_norm_period, spm_done, sys_hard_fault,
    input  osp_pu_req, osp_sd_req, osp_rst_n, putest_status, sdtest_status, osprst_status,
           cmd_busy, cmd_err, fifo_level
  );

  modport slave (
    input  mcu_cmd, mcu_cmd_write, s2_norm_period, s4_norm_period, spm_done, sys_hard_fault,
    output osp_pu_req, osp_sd_req, osp_rst_n, putest_status, sdtest_status, osprst_status,
           cmd_busy, cmd_err, fifo_level
  );
endinterface

// File: rtl/osp_cmd_fifo.sv
// Synchronous command FIFO with flush; a push into a full FIFO is dropped unless a pop frees room.
module osp_cmd_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_ovf,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_level   = r_cnt;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
  assign o_ovf     = i_push && !i_flush && o_full && !w_do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/osp_cmd_engine.sv
// Multi-channel OSP command sequencer: FIFO-fed decode of PM / SD / RST / CLR commands per mask.
module osp_cmd_engine
  import osp_cmd_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CMD_KEY    = 8'h24,
  parameter int unsigned TMO_W      = 16,
  parameter int unsigned TMO_CYC    = 1000,
  parameter int unsigned RST_CYC    = 8
) (
  input logic              clk,
  input logic              reset_n,
  osp_cmd_engine_if.slave  bus
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_e           r_state;
  logic [15:0]      r_cmd;
  logic [TMO_W-1:0] r_tmo;
  logic [NCH-1:0]   r_pu, r_sd, r_rst_n, r_sdtest, r_osprst;
  logic [4*NCH-1:0] r_putest;
  logic [3:0]       r_err;

  logic [15:0]      w_head;
  logic             w_full, w_empty, w_ovf, w_push, w_pop, w_flush, w_fault;
  logic [LW-1:0]    w_level;
  logic [NCH-1:0]   w_mask, w_pm_adv, w_sd_adv;
  logic             w_pm_done, w_sd_done, w_tmo_hit, w_valid_clr, w_valid_run;
  logic [3:0]       w_op;

  assign w_fault = bus.sys_hard_fault;
  assign w_push  = bus.mcu_cmd_write && !w_fault;
  assign w_pop   = (r_state == StIdle) && !w_fault;
  assign w_flush = (r_state == StAbort) || ((r_state == StIdle) && w_fault);

  osp_cmd_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (bus.mcu_cmd),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ovf   (w_ovf),
    .o_level (w_level)
  );

  // Slicing to NCH bits drops mask bits for channels that do not exist.
  assign w_mask      = r_cmd[4 +: NCH];
  assign w_op        = r_cmd[3:0];
  assign w_valid_clr = (r_cmd[15:8] == CMD_KEY) && (w_op == OpClr);
  assign w_valid_run = (r_cmd[15:8] == CMD_KEY) && (|w_mask) &&
                       ((w_op == OpPm) || (w_op == OpSd) || (w_op == OpRst));
  assign w_tmo_hit   = (r_tmo == TMO_W'(TMO_CYC));

  always_comb begin
    w_pm_adv  = '0;
    w_sd_adv  = '0;
    w_pm_done = 1'b1;
    w_sd_done = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_mask[i]) begin
        if (((r_putest[4*i +: 4] == PuWaitS2)  && bus.s2_norm_period[i]) ||
            ((r_putest[4*i +: 4] == PuWaitS4)  && bus.s4_norm_period[i]) ||
            ((r_putest[4*i +: 4] == PuWaitSpm) && bus.spm_done[i])) begin
          w_pm_adv[i] = 1'b1;
        end
        if ((r_putest[4*i +: 4] != PuPass) && (r_putest[4*i +: 4] != PuTmo)) w_pm_done = 1'b0;
        if (r_sd[i] && !bus.s2_norm_period[i] && !bus.s4_norm_period[i]) w_sd_adv[i] = 1'b1;
        if (r_sd[i]) w_sd_done = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cmd    <= '0;
      r_tmo    <= '0;
      r_pu     <= '0;
      r_sd     <= '0;
      r_rst_n  <= '1;
      r_sdtest <= '0;
      r_osprst <= '0;
      r_putest <= '0;
      r_err    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_fault && !w_empty) begin
            r_cmd   <= w_head;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          if (w_fault) begin
            r_state <= StAbort;
          end else if (w_valid_clr) begin
            r_err    <= '0;
            r_putest <= '0;
            r_sdtest <= '0;
            r_osprst <= '0;
            r_state  <= StIdle;
          end else if (!w_valid_run) begin
            r_err[ErrCmd] <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_tmo <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
              if (w_mask[i]) begin
                case (w_op)
                  OpPm: begin
                    r_putest[4*i +: 4] <= PuWaitS2;
                    r_pu[i]            <= 1'b1;
                  end
                  OpSd: begin
                    r_sdtest[i] <= 1'b0;
                    r_pu[i]     <= 1'b0;
                    r_sd[i]     <= 1'b1;
                  end
                  default: begin
                    r_osprst[i] <= 1'b0;
                    r_rst_n[i]  <= 1'b0;
                  end
                endcase
              end
            end
            case (w_op)
              OpPm:    r_state <= StPmRun;
              OpSd:    r_state <= StSdRun;
              default: r_state <= StRstPulse;
            endcase
          end
        end
        StPmRun: begin
          if (w_fault) begin
            r_state <= StAbort;
          end else if (w_pm_done) begin
            r_state <= StIdle;
          end else if (w_tmo_hit) begin
            r_err[ErrTmo] <= 1'b1;
            for (int unsigned i = 0; i < NCH; i++) begin
              if (w_mask[i] && pu_busy(r_putest[4*i +: 4])) begin
                r_putest[4*i +: 4] <= PuTmo;
                r_pu[i]            <= 1'b0;
              end
            end
            r_state <= StIdle;
          end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
              if (w_pm_adv[i]) r_putest[4*i +: 4] <= pu_next(r_putest[4*i +: 4]);
            end
            r_tmo <= (|w_pm_adv) ? '0 : r_tmo + TMO_W'(1);
          end
        end
        StSdRun: begin
          if (w_fault) begin
            r_state <= StAbort;
          end else if (w_sd_done) begin
            r_state <= StIdle;
          end else if (w_tmo_hit) begin
            r_err[ErrTmo] <= 1'b1;
            r_sd          <= r_sd & ~w_mask;
            r_state       <= StIdle;
          end else begin
            r_sdtest <= r_sdtest | w_sd_adv;
            r_sd     <= r_sd & ~w_sd_adv;
            r_tmo    <= (|w_sd_adv) ? '0 : r_tmo + TMO_W'(1);
          end
        end
        StRstPulse: begin
          if (w_fault) begin
            r_state <= StAbort;
          end else if (r_tmo == TMO_W'(RST_CYC - 1)) begin
            for (int unsigned i = 0; i < NCH; i++) begin
              if (w_mask[i]) begin
                r_rst_n[i]         <= 1'b1;
                r_osprst[i]        <= 1'b1;
                r_putest[4*i +: 4] <= PuIdle;
                r_sdtest[i]        <= 1'b0;
                r_pu[i]            <= 1'b0;
              end
            end
            r_state <= StIdle;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        StAbort: begin
          r_pu    <= '0;
          r_sd    <= '0;
          r_rst_n <= '1;
          for (int unsigned i = 0; i < NCH; i++) begin
            if (pu_busy(r_putest[4*i +: 4])) r_putest[4*i +: 4] <= PuAbort;
          end
          r_err[ErrFault] <= 1'b1;
          r_state         <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      // Overflow lands after the case so a same-cycle CLR cannot hide it.
      if (w_ovf) r_err[ErrOvf] <= 1'b1;
    end
  end

  assign bus.osp_pu_req    = r_pu;
  assign bus.osp_sd_req    = r_sd;
  assign bus.osp_rst_n     = r_rst_n;
  assign bus.putest_status = r_putest;
  assign bus.sdtest_status = r_sdtest;
  assign bus.osprst_status = r_osprst;
  assign bus.cmd_err       = r_err;
  assign bus.cmd_busy      = (r_state != StIdle);
  assign bus.fifo_level    = w_level;
endmodule

// File: doc/osp_cmd_engine.md
Name: osp_cmd_engine

Overview:
- Parametrised, multi-channel successor to the single-channel OSP command generator.
- Accepts 16-bit MCU command words into a small FIFO and decodes them.
- Sequences power-up test (PM), shutdown test (SD) and OSP reset (RST) on a per-command channel mask, with a timeout and hard-fault abort.
- Sits between the MCU register interface and the per-channel OSP power/period monitors.

Parameters:
- NCH, 4, number of OSP channels (1..4).
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
- CMD_KEY, 8'h24, required value of mcu_cmd[15:8].
- TMO_W, 16, timeout counter width.
- TMO_CYC, 1000, cycles allowed per PM/SD step before timeout.
- RST_CYC, 8, osp_rst_n low-pulse length in cycles.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mcu_cmd  in  16  command word: [15:8] key, [7:4] channel mask, [3:0] opcode
- mcu_cmd_write  in  1  one FIFO push per cycle while high
- s2_norm_period  in  NCH  per-channel stage-2 period normal
- s4_norm_period  in  NCH  per-channel stage-4 period normal
- spm_done  in  NCH  per-channel SPM complete
- sys_hard_fault  in  1  global fault, level
- osp_pu_req  out  NCH  power-up request
- osp_sd_req  out  NCH  shutdown request
- osp_rst_n  out  NCH  OSP reset, active low
- putest_status  out  4*NCH  per-channel PM status, nibble i = channel i
- sdtest_status  out  NCH  1 = SD pass
- osprst_status  out  NCH  1 = reset pulse completed
- cmd_busy  out  1  sequencer not IDLE
- cmd_err  out  4  sticky: [0] bad key/opcode, [1] FIFO overflow, [2] timeout, [3] fault abort
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset values:
  - osp_rst_n all 1; all other outputs 0.
  - FIFO empty; FSM in IDLE.
- Opcodes: 0 CLR, 1 PM, 5 SD, 6 RST. Mask bits >= NCH are ignored.
- Push rules:
  - A push when full drops the word and sets cmd_err[1].
  - A push and pop in the same cycle are both honoured; level is unchanged.
- Pop and decode:
  - Pop only in IDLE, one cycle after the word is visible. Write at cycle N gives decode at N+1 and outputs at N+2.
  - Key mismatch, unknown opcode, or a mask that is all zero after clipping to NCH: set cmd_err[0], return to IDLE.
- CLR: clears cmd_err and all status outputs for all channels.
- PM:
  - Masked channels: set osp_pu_req; putest nibble steps 1 (wait s2) -> 2 (wait s4) -> 3 (wait spm_done) -> 8 (pass).
  - Each channel advances independently, one step per cycle max.
  - The timeout counter restarts whenever any masked channel advances.
  - If the counter reaches TMO_CYC, unfinished channels get nibble 9 and cmd_err[2] is set.
  - Exit when all masked channels are 8 or 9. osp_pu_req stays high on passed channels and drops on timed-out ones.
- SD:
  - Masked channels: clear sdtest bit, drop osp_pu_req, assert osp_sd_req.
  - A channel passes when s2_norm_period and s4_norm_period are both 0; its sdtest bit is set and osp_sd_req drops.
  - Timeout rule as for PM; on timeout set cmd_err[2] and drop osp_sd_req.
- RST:
  - Masked channels: clear osprst bit, drive osp_rst_n low for exactly RST_CYC cycles, then high.
  - osprst bit is set on the first high cycle. Also clears that channel's putest nibble, sdtest bit and osp_pu_req.
- FSM states: IDLE, DECODE, PM_RUN, SD_RUN, RST_PULSE, ABORT. Every non-IDLE state exits to IDLE.
- Fault:
  - sys_hard_fault high in any non-IDLE state -> ABORT for one cycle.
  - In ABORT: all req outputs drop, osp_rst_n goes high, in-progress PM nibbles become 4'hF, the FIFO is flushed, cmd_err[3] is set, then IDLE.
  - Fault while IDLE: flush the FIFO only.
  - FIFO pushes are ignored while the fault is high.
- Async reset mid-operation returns everything to reset values immediately.

Decomposition:
- Package osp_cmd_pkg holds:
  - opcode constants;
  - putest codes (0 idle, 1/2/3 busy, 8 pass, 9 timeout, F abort);
  - FSM state enum;
  - cmd_err bit indices.
- Sub-module osp_cmd_fifo: synchronous FIFO with push/pop/flush, full, empty and level outputs.

Test Plan:
- Reset, then write 0x2471 for one cycle; raise s2, s4, spm_done on channels 0–2 at 10-cycle spacing -> nibbles 0–2 step 1,2,3,8; nibble 3 stays 0; osp_pu_req = 4'b0111.
- Write 0x2415 with both period inputs dropped 20 cycles later -> sdtest_status = 4'b0001; osp_sd_req[0] high for ~20 cycles, then low.
- Write 0x24F6 -> osp_rst_n = 4'b0000 for exactly 8 cycles; osprst_status = 4'b1111 on cycle 9; putest all 0.
- Write 0x2411 with s2 never rising -> nibble 0 = 9 after 1000 cycles; cmd_err = 4'b0100; cmd_busy falls.
- Hold mcu_cmd_write high 6 cycles with 0x2471 while a PM runs -> fifo_level saturates at 4; cmd_err[1] set. Then pulse sys_hard_fault -> nibbles 0–2 = F, fifo_level = 0, cmd_err[3] set.
- Write 0x3371, then 0x2473, then 0x2400 -> cmd_err[0] set after each of the first two; all status and cmd_err = 0 after the third.
